io_share_arbiter: RTL and testbench
===================================

IO_SHARE_ARBITER -- requirements
Module: io_share_arbiter

Interface
REQ-001 Parameter NPINS, default 19, number of shared pads.
REQ-002 Parameter TURN_CYCLES, default 2, all-pads-tristated cycles on every ownership change; legal range is 1 to 15.
REQ-003 Parameter MIN_GPIO, default 4, minimum GPIO-owner dwell cycles before a new external-bus grant; legal range is 0 to 255.
REQ-004 The block SHALL have one clock, ext_clk; reset is ext_rst_n, asynchronous and active-low.
REQ-005 Ports, as name, direction, width, meaning:
- ext_clk, in, 1: clock.
- ext_rst_n, in, 1: async active-low reset.
- xb_req, in, 1: external bus requests the pads.
- xb_gnt, out, 1: external bus owns the pads.
- xb_out, in, NPINS: bus output data.
- xb_oe, in, NPINS: bus drive enables, 1 = drive.
- xb_in, out, NPINS: pad data to the bus.
- gpio_out, in, NPINS: GPIO output data.
- gpio_dir, in, NPINS: GPIO direction, 1 = output.
- gpio_in, out, NPINS: pad data to GPIO.
- force_gpio, in, 1: config override, GPIO keeps or takes the pads.
- pad_in, in, NPINS: pad input.
- pad_out, out, NPINS: pad output.
- pad_oeb, out, NPINS: pad output enable, active-low.
- owner, out, 2: current state encoding.

Function
REQ-006 The block SHALL implement states GPIO (owner=00), TURN_XB (01), XB (10) and TURN_GPIO (11), held in a register.
REQ-007 The block SHALL keep a turn counter that is loaded on entry to TURN_XB or TURN_GPIO, so that each TURN state lasts exactly TURN_CYCLES cycles.
REQ-008 The block SHALL keep a dwell counter that is loaded with MIN_GPIO on entry to GPIO and decrements to 0 while in GPIO.
REQ-009 In GPIO, when xb_req=1 and force_gpio=0 and dwell=0, the block SHALL go to TURN_XB on the next edge; otherwise it stays in GPIO.
REQ-010 When the TURN_XB count expires, the block SHALL go to XB; if xb_req=0 or force_gpio=1 in the last TURN_XB cycle, it SHALL go to TURN_GPIO instead.
REQ-011 In XB, when xb_req=0 or force_gpio=1, the block SHALL go to TURN_GPIO on the next edge.
REQ-012 When the TURN_GPIO count expires, the block SHALL always go to GPIO; a re-asserted xb_req is evaluated only from GPIO, subject to the dwell counter.
REQ-013 xb_gnt SHALL be 1 only while the state is XB; it is decoded from the state register and is glitch-free.
REQ-014 Pad outputs per state:
- In GPIO: pad_out=gpio_out and pad_oeb=~gpio_dir.
- In XB: pad_out=xb_out and pad_oeb=~xb_oe.
- In TURN_XB and TURN_GPIO: pad_out=0 and pad_oeb all 1s.
REQ-015 gpio_in SHALL equal pad_in in GPIO; in any other state it SHALL hold a register capturing pad_in on each GPIO cycle.
REQ-016 xb_in SHALL equal pad_in in XB and all 0s otherwise.
REQ-017 Outputs SHALL be combinational from the state register and the data inputs only; xb_req and force_gpio SHALL affect outputs only through the state register.
REQ-018 Both counters SHALL saturate at 0 and never wrap.
REQ-019 The GPIO-to-XB latency from xb_req rising, with dwell=0, SHALL be TURN_CYCLES+1 edges.
REQ-020 The XB-to-GPIO latency from xb_req falling SHALL be TURN_CYCLES+1 edges.
REQ-021 When xb_req and force_gpio change in the same cycle, force_gpio SHALL take priority.

Reset
REQ-022 While ext_rst_n=0, the block SHALL asynchronously enter TURN_GPIO with the turn counter at TURN_CYCLES, dwell=0, and the gpio_in hold register at 0.
REQ-023 While ext_rst_n=0, the outputs SHALL be xb_gnt=0, pad_oeb all 1s, pad_out=0, xb_in=0, gpio_in=0 and owner=11.
REQ-024 After ext_rst_n deasserts, the block SHALL tristate the pads for TURN_CYCLES edges, then enter GPIO.
REQ-025 Reset asserted in any state, including XB mid-transfer, SHALL drop xb_gnt and tristate the pads in the same cycle, without waiting for a clock edge.

Verification
REQ-026 The bench SHALL cover these directed scenarios, using defaults NPINS=19, TURN_CYCLES=2, MIN_GPIO=4:
- Reset release with xb_req=0: pad_oeb=0x7FFFF for 2 cycles, then owner=00 and pad_oeb=~gpio_dir.
- xb_req=1 held from GPIO with dwell expired: owner=01 for 2 cycles, then owner=10 and xb_gnt=1 on edge 3; xb_oe=0x003FF gives pad_oeb=0x7FC00.
- xb_req dropped in XB, then re-raised 1 cycle later: 2 TURN_GPIO cycles, 4 GPIO cycles, 2 TURN_XB cycles, then XB; xb_gnt stays 0 for exactly 8 cycles.
- force_gpio=1 raised in XB with xb_req still 1: xb_gnt falls on the next edge and GPIO is reached after 2 tristate cycles; while force_gpio=1 the block remains in GPIO indefinitely.
- ext_rst_n pulled low mid-XB with pad_in=0x12345: xb_gnt=0, pad_oeb=0x7FFFF and gpio_in=0 without a clock edge.
- pad_in=0x0ABCD in GPIO, then the block moves to XB while pad_in changes to 0x55555: gpio_in holds 0x0ABCD and xb_in=0x55555 in XB.

Source files
------------

// File: rtl/io_share_arbiter.sv
// Hands the shared pads between GPIO and an external bus, tristating everything for TURN_CYCLES on every handover.
// Handover takes TURN_CYCLES+1 edges; the bus waits for xb_gnt and GPIO keeps the pads for at least MIN_GPIO cycles.
module io_share_arbiter #(
   parameter int NPINS       = 19,
   parameter int TURN_CYCLES = 2,
   parameter int MIN_GPIO    = 4
) (
   input  logic             ext_clk,
   input  logic             ext_rst_n,
   input  logic             xb_req,
   output logic             xb_gnt,
   input  logic [NPINS-1:0] xb_out,
   input  logic [NPINS-1:0] xb_oe,
   output logic [NPINS-1:0] xb_in,
   input  logic [NPINS-1:0] gpio_out,
   input  logic [NPINS-1:0] gpio_dir,
   output logic [NPINS-1:0] gpio_in,
   input  logic             force_gpio,
   input  logic [NPINS-1:0] pad_in,
   output logic [NPINS-1:0] pad_out,
   output logic [NPINS-1:0] pad_oeb,
   output logic [1:0]       owner
);

   typedef enum logic [1:0] {
      ST_GPIO      = 2'b00,
      ST_TURN_XB   = 2'b01,
      ST_XB        = 2'b10,
      ST_TURN_GPIO = 2'b11
   } state_t;

   localparam logic [3:0] TURN_LD  = 4'(TURN_CYCLES);
   localparam logic [7:0] DWELL_LD = 8'(MIN_GPIO);

   state_t           state_q, state_d;
   logic [3:0]       turn_q, turn_d;
   logic [7:0]       dwell_q, dwell_d;
   logic [7:0]       dwell_dec;
   logic [NPINS-1:0] hold_q;
   logic             want_xb;
   logic             turn_last;

   // force_gpio masks the request so it always wins over a simultaneous xb_req change
   assign want_xb   = xb_req & ~force_gpio;
   assign turn_last = (turn_q <= 4'd1);
   assign dwell_dec = (dwell_q != 8'd0) ? dwell_q - 8'd1 : 8'd0;

   always_comb begin
      state_d = state_q;
      turn_d  = turn_q;
      dwell_d = dwell_q;
      case (state_q)
         ST_GPIO: begin
            dwell_d = dwell_dec;
            // GPIO may be left in the cycle the dwell reaches zero, so it lasts MIN_GPIO cycles (at least one)
            if (want_xb && dwell_dec == 8'd0) begin
               state_d = ST_TURN_XB;
               turn_d  = TURN_LD;
            end
         end
         ST_TURN_XB: begin
            if (turn_last) begin
               if (want_xb) begin
                  state_d = ST_XB;
               end else begin
                  state_d = ST_TURN_GPIO;
                  turn_d  = TURN_LD;
               end
            end else begin
               turn_d = turn_q - 4'd1;
            end
         end
         ST_XB: begin
            if (!want_xb) begin
               state_d = ST_TURN_GPIO;
               turn_d  = TURN_LD;
            end
         end
         default: begin
            if (turn_last) begin
               state_d = ST_GPIO;
               dwell_d = DWELL_LD;
            end else begin
               turn_d = turn_q - 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge ext_clk or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         state_q <= ST_TURN_GPIO;
         turn_q  <= TURN_LD;
         dwell_q <= 8'd0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         turn_q  <= turn_d;
         dwell_q <= dwell_d;
         if (state_q == ST_GPIO) begin
            hold_q <= pad_in;
         end
      end
   end

   assign owner = state_q;

   always_comb begin
      xb_gnt  = 1'b0;
      pad_out = '0;
      pad_oeb = '1;
      xb_in   = '0;
      gpio_in = hold_q;
      case (state_q)
         ST_GPIO: begin
            pad_out = gpio_out;
            pad_oeb = ~gpio_dir;
            gpio_in = pad_in;
         end
         ST_XB: begin
            xb_gnt  = 1'b1;
            pad_out = xb_out;
            pad_oeb = ~xb_oe;
            xb_in   = pad_in;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_io_share_arbiter.sv
// Bench for io_share_arbiter: directed handover scenarios plus randomized traffic against a cycle-age model.
module tb_io_share_arbiter;

   localparam int N     = 19;
   localparam int TURN  = 2;
   localparam int DWELL = 4;

   logic         ext_clk = 1'b0;
   logic         ext_rst_n;
   logic         xb_req, force_gpio;
   logic         xb_gnt;
   logic [N-1:0] xb_out, xb_oe, xb_in;
   logic [N-1:0] gpio_out, gpio_dir, gpio_in;
   logic [N-1:0] pad_in, pad_out, pad_oeb;
   logic [1:0]   owner;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   io_share_arbiter #(.NPINS(N), .TURN_CYCLES(TURN), .MIN_GPIO(DWELL)) dut (
      .ext_clk(ext_clk), .ext_rst_n(ext_rst_n),
      .xb_req(xb_req), .xb_gnt(xb_gnt),
      .xb_out(xb_out), .xb_oe(xb_oe), .xb_in(xb_in),
      .gpio_out(gpio_out), .gpio_dir(gpio_dir), .gpio_in(gpio_in),
      .force_gpio(force_gpio), .pad_in(pad_in),
      .pad_out(pad_out), .pad_oeb(pad_oeb), .owner(owner)
   );

   always #5 ext_clk = ~ext_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: owner 0=GPIO 1=TURN_XB 2=XB 3=TURN_GPIO; age counts cycles already spent in the current owner
   int           m_st  = 3;
   int           m_age = 0;
   logic [N-1:0] m_hold = '0;

   always @(posedge ext_clk or negedge ext_rst_n) begin : model
      int  nx;
      bit  want;
      if (!ext_rst_n) begin
         m_st   <= 3;
         m_age  <= 0;
         m_hold <= '0;
      end else begin
         want = xb_req && !force_gpio;
         nx   = m_st;
         case (m_st)
            0: begin
               m_hold <= pad_in;
               if (want && m_age + 1 >= DWELL) nx = 1;
            end
            1: if (m_age + 1 >= TURN) nx = want ? 2 : 3;
            2: if (!want) nx = 3;
            default: if (m_age + 1 >= TURN) nx = 0;
         endcase
         m_st  <= nx;
         m_age <= (nx != m_st) ? 0 : m_age + 1;
      end
   end

   always @(negedge ext_clk) begin : compare
      logic [N-1:0] e_pout, e_oeb, e_gin, e_xin;
      #2;
      if (chk_en) begin
         e_pout = '0; e_oeb = '1; e_gin = m_hold; e_xin = '0;
         if (m_st == 0) begin
            e_pout = gpio_out; e_oeb = ~gpio_dir; e_gin = pad_in;
         end else if (m_st == 2) begin
            e_pout = xb_out; e_oeb = ~xb_oe; e_xin = pad_in;
         end
         chk("owner",   32'(owner),   32'(m_st));
         chk("xb_gnt",  32'(xb_gnt),  32'(m_st == 2));
         chk("pad_out", 32'(pad_out), 32'(e_pout));
         chk("pad_oeb", 32'(pad_oeb), 32'(e_oeb));
         chk("gpio_in", 32'(gpio_in), 32'(e_gin));
         chk("xb_in",   32'(xb_in),   32'(e_xin));
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int  lowcnt;
      bit  seen;
      ext_rst_n = 1'b1;
      xb_req = 0; force_gpio = 0;
      xb_out = '0; xb_oe = '0;
      gpio_out = 19'h12321; gpio_dir = 19'h0F0F0; pad_in = 19'h00F00;
      #1 ext_rst_n = 1'b0;
      #1 chk_en = 1'b1;
      #2;
      chk("rst_owner",   32'(owner),   32'h3);
      chk("rst_pad_oeb", 32'(pad_oeb), 32'h7FFFF);
      chk("rst_xb_gnt",  32'(xb_gnt),  32'h0);
      chk("rst_gpio_in", 32'(gpio_in), 32'h0);
      chk("rst_pad_out", 32'(pad_out), 32'h0);
      chk("rst_xb_in",   32'(xb_in),   32'h0);

      // reset release: two tristate cycles then GPIO
      @(negedge ext_clk); ext_rst_n = 1'b1;
      #3 chk("rel_c1_oeb", 32'(pad_oeb), 32'h7FFFF);
      @(negedge ext_clk); #3 chk("rel_c2_owner", 32'(owner), 32'h3);
      @(negedge ext_clk); #3 chk("rel_gpio_owner", 32'(owner), 32'h0);
      chk("rel_gpio_oeb", 32'(pad_oeb), 32'h70F0F);
      chk("rel_gpio_in",  32'(gpio_in), 32'h00F00);

      // GPIO -> XB with hold of the last GPIO pad sample
      repeat (5) @(negedge ext_clk);
      pad_in = 19'h0ABCD;
      @(negedge ext_clk);
      xb_req = 1; xb_oe = 19'h003FF; xb_out = 19'h2AAAA;
      #3 chk("acq_w0_owner", 32'(owner), 32'h0);
      @(negedge ext_clk); pad_in = 19'h55555;
      #3 chk("acq_w1_owner", 32'(owner), 32'h1);
      chk("acq_w1_gpio_in", 32'(gpio_in), 32'h0ABCD);
      chk("acq_w1_pad_out", 32'(pad_out), 32'h0);
      @(negedge ext_clk); #3 chk("acq_w2_owner", 32'(owner), 32'h1);
      chk("acq_w2_gnt", 32'(xb_gnt), 32'h0);
      @(negedge ext_clk); #3 chk("acq_w3_owner", 32'(owner), 32'h2);
      chk("acq_gnt",     32'(xb_gnt),  32'h1);
      chk("acq_pad_oeb", 32'(pad_oeb), 32'h7FC00);
      chk("acq_pad_out", 32'(pad_out), 32'h2AAAA);
      chk("acq_xb_in",   32'(xb_in),   32'h55555);
      chk("acq_gpio_in", 32'(gpio_in), 32'h0ABCD);

      // drop and re-raise: gnt low for TURN + DWELL + TURN cycles
      @(negedge ext_clk); xb_req = 0;
      #3 chk("drop_w0_gnt", 32'(xb_gnt), 32'h1);
      @(negedge ext_clk); xb_req = 1;
      lowcnt = 0; seen = 0;
      for (int k = 0; k < 30 && !seen; k++) begin
         #3;
         if (xb_gnt) seen = 1;
         else begin
            lowcnt++;
            @(negedge ext_clk);
         end
      end
      chk("reacq_seen",     32'(seen),   32'h1);
      chk("reacq_low_cycs", 32'(lowcnt), 32'd8);

      // force_gpio while the bus still requests
      @(negedge ext_clk); force_gpio = 1;
      #3 chk("force_w0_gnt", 32'(xb_gnt), 32'h1);
      @(negedge ext_clk); #3 chk("force_w1_gnt", 32'(xb_gnt), 32'h0);
      chk("force_w1_oeb", 32'(pad_oeb), 32'h7FFFF);
      @(negedge ext_clk); #3 chk("force_w2_owner", 32'(owner), 32'h3);
      @(negedge ext_clk); #3 chk("force_w3_owner", 32'(owner), 32'h0);
      for (int k = 0; k < 20; k++) begin
         @(negedge ext_clk); #3 chk("force_hold_owner", 32'(owner), 32'h0);
      end
      @(negedge ext_clk); force_gpio = 0;
      #3 chk("unforce_w0_owner", 32'(owner), 32'h0);
      @(negedge ext_clk); #3 chk("unforce_w1_owner", 32'(owner), 32'h1);
      @(negedge ext_clk);
      @(negedge ext_clk); pad_in = 19'h12345;
      #3 chk("mid_xb_owner", 32'(owner), 32'h2);

      // asynchronous reset in the middle of a bus transfer
      @(posedge ext_clk); #2 ext_rst_n = 1'b0;
      #1;
      chk("arst_gnt",     32'(xb_gnt),  32'h0);
      chk("arst_pad_oeb", 32'(pad_oeb), 32'h7FFFF);
      chk("arst_gpio_in", 32'(gpio_in), 32'h0);
      chk("arst_owner",   32'(owner),   32'h3);
      chk("arst_xb_in",   32'(xb_in),   32'h0);
      @(negedge ext_clk); ext_rst_n = 1'b1;

      // randomized traffic checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         @(negedge ext_clk);
         if ($urandom_range(0, 9) == 0) xb_req = ~xb_req;
         if ($urandom_range(0, 39) == 0) force_gpio = ~force_gpio;
         ext_rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         xb_out   = N'($urandom);
         xb_oe    = N'($urandom);
         gpio_out = N'($urandom);
         gpio_dir = N'($urandom);
         pad_in   = N'($urandom);
      end
      @(negedge ext_clk); ext_rst_n = 1'b1;
      @(negedge ext_clk); #3;
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
